imm_gen_pipe: RTL
=================

Name: imm_gen_pipe

Overview:
Pipelined, parametrised immediate generator for the decode stage. Covers every RV32I/RV64I immediate format (I, S, B, U, J, shift-amount), not only a fixed ADDI/SRAI/LW/SW/BEQ subset. Registered output with valid/ready handshake and a 2-entry skid buffer, so the decode stage stalls without losing instructions. Carries a sideband tag (PC or ROB index) alongside each result, and supports a synchronous pipeline flush.

Parameters:
XLEN, 32, immediate output width; legal values 32 or 64 only.
TAG_W, 32, width of the sideband tag carried with each instruction.

Ports:
clk_i  input  1  clock, rising-edge.
rst_i  input  1  reset, asynchronous, active-low.
flush_i  input  1  synchronous flush; drops all buffered entries.
in_valid_i  input  1  instruction word valid.
in_ready_o  output  1  block can accept an instruction this cycle.
instr_i  input  32  instruction word.
tag_i  input  TAG_W  sideband tag.
out_valid_o  output  1  result valid.
out_ready_i  input  1  consumer accepts the result.
imm_o  output  XLEN  generated immediate.
fmt_o  output  3  format code: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT, 7 ZIMM.
illegal_o  output  1  opcode is not recognised.
tag_o  output  TAG_W  tag of the presented result.

Behaviour:
- Reset (rst_i low, async): buffer EMPTY; out_valid_o=0, imm_o=0, fmt_o=0, illegal_o=0, tag_o=0, in_ready_o=1 after release.
- Decode is combinational on instr_i and is captured on accept (in_valid_i & in_ready_o). Result appears on outputs the next cycle; latency is 1 when the block is not stalled.
- Opcode map (instr_i[6:0]):
  - 0000011 LOAD, 1100111 JALR, 1110011 SYSTEM -> I.
  - 0010011 OP-IMM: funct3 001/101 -> SHAMT; other funct3 -> I.
  - 0100011 -> S. 1100011 -> B. 0110111 / 0010111 -> U. 1101111 -> J.
  - Any other opcode -> imm 0, fmt NONE, illegal_o=1.
- Formats, each sign-extended from instr_i[31] to XLEN:
  - I = instr[31:20].
  - S = {instr[31:25], instr[11:7]}.
  - B = {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U = {instr[31:12], 12'b0}.
  - J = {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
- SHAMT is zero-extended: instr[24:20] when XLEN=32, instr[25:20] when XLEN=64. funct7 bits are never part of imm_o.
- Buffer FSM: EMPTY / ONE / TWO (output register plus skid register).
  - EMPTY + accept -> ONE.
  - ONE + accept without pop -> TWO.
  - ONE + pop without accept -> EMPTY.
  - ONE + accept & pop -> ONE.
  - TWO + pop -> ONE, skid entry moves to the output register.
  - No accept is possible in TWO.
- in_ready_o = (state != TWO). It is registered state only, with no combinational path from out_ready_i.
- out_valid_o = (state != EMPTY). Outputs hold stable while out_valid_o & !out_ready_i.
- Ordering is strictly FIFO.
- flush_i: next state EMPTY and out_valid_o=0 next cycle. Flush wins over a simultaneous accept and pop; an instruction offered in the flush cycle is discarded.
- Reset asserted mid-operation clears all entries immediately, regardless of clock.

Optional Feature:
IMM_GEN_ZIMM_EN
- Defined: SYSTEM with funct3[2]=1 (CSRRWI/CSRRSI/CSRRCI) -> fmt ZIMM, imm = zero-extended instr[19:15]. SYSTEM with funct3[2]=0 stays I.
- Undefined: all SYSTEM -> I; fmt code 7 is never produced.

Test Plan:
1. out_ready_i=1; send 0xFFF00093 (addi -1), then 0x12345037 (lui) -> 0xFFFFFFFF fmt I, then 0x12345000 fmt U, one cycle apart, latency 1 each.
2. Send 0x4030D093 (srai x1,x1,3) -> imm 0x00000003, fmt SHAMT; must not be 0x403.
3. Send 0xFE112E23 (sw -4) -> 0xFFFFFFFC fmt S. Send 0xFE000CE3 (beq -8) -> 0xFFFFFFF8 fmt B. Send 0x0000007F -> imm 0, fmt NONE, illegal_o=1. Repeat with XLEN=64: sign extension reaches 0xFFFFFFFFFFFFFFFC.
4. out_ready_i=0; offer 3 instructions with tags 1, 2, 3 -> in_ready_o drops after 2 accepts. Raise out_ready_i -> tags 1, 2, 3 emerge in order with no loss or duplication.
5. Buffer in TWO; assert flush_i together with in_valid_i -> next cycle out_valid_o=0, in_ready_o=1, flushed entries never appear.
6. With ONE entry held, pulse rst_i low between clock edges -> out_valid_o=0 immediately. With IMM_GEN_ZIMM_EN: 0x3052D073 -> imm 0x5, fmt ZIMM; without the macro -> imm 0x305, fmt I.

Source files
------------

// File: rtl/imm_gen_pipe_if.sv
// imm_gen_pipe_if: decode-stage handshake bundle for the immediate generator.
// The slave modport is the generator's view; the master modport is the decode stage's view.
interface imm_gen_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
);
    logic             flush_i;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [31:0]      instr_i;
    logic [TAG_W-1:0] tag_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [XLEN-1:0]  imm_o;
    logic [2:0]       fmt_o;
    logic             illegal_o;
    logic [TAG_W-1:0] tag_o;

    modport slave (
        input  flush_i, in_valid_i, instr_i, tag_i, out_ready_i,
        output in_ready_o, out_valid_o, imm_o, fmt_o, illegal_o, tag_o
    );

    modport master (
        output flush_i, in_valid_i, instr_i, tag_i, out_ready_i,
        input  in_ready_o, out_valid_o, imm_o, fmt_o, illegal_o, tag_o
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: RV32I/RV64I immediate generator with a 2-entry skid buffer and flush.
// Define IMM_GEN_ZIMM_EN to decode CSR*I instructions as the ZIMM format.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input logic          clk_i,
    input logic          rst_i,
    imm_gen_pipe_if.slave bus
);
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [2:0]       fmt;
        logic             ill;
        logic [TAG_W-1:0] tag;
    } ent_t;

    localparam logic [2:0] F_I     = 3'd1;
    localparam logic [2:0] F_S     = 3'd2;
    localparam logic [2:0] F_B     = 3'd3;
    localparam logic [2:0] F_U     = 3'd4;
    localparam logic [2:0] F_J     = 3'd5;
    localparam logic [2:0] F_SHAMT = 3'd6;

    logic [31:0]     w;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
    logic            is_sh;
    ent_t            dec;
    state_t          state_q, state_d;
    ent_t            out_q, out_d, skid_q, skid_d;
    logic            acc, pop;

    assign w      = bus.instr_i;
    assign imm_i  = XLEN'($signed(w[31:20]));
    assign imm_s  = XLEN'($signed({w[31:25], w[11:7]}));
    assign imm_b  = XLEN'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
    assign imm_u  = XLEN'($signed({w[31:12], 12'b0}));
    assign imm_j  = XLEN'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
    // Shift amounts widen to 6 bits on RV64; funct7 never leaks into the immediate
    assign imm_sh = (XLEN == 64) ? XLEN'(w[25:20]) : XLEN'(w[24:20]);
    assign is_sh  = (w[14:12] == 3'b001) || (w[14:12] == 3'b101);

`ifdef IMM_GEN_ZIMM_EN
    logic [XLEN-1:0] imm_z;
    assign imm_z = XLEN'(w[19:15]);
`endif

    always_comb begin
        dec     = '0;
        dec.tag = bus.tag_i;
        case (w[6:0])
            7'b0000011, 7'b1100111: begin dec.fmt = F_I; dec.imm = imm_i; end
            7'b1110011: begin
`ifdef IMM_GEN_ZIMM_EN
                dec.fmt = w[14] ? 3'd7 : F_I;
                dec.imm = w[14] ? imm_z : imm_i;
`else
                dec.fmt = F_I;
                dec.imm = imm_i;
`endif
            end
            7'b0010011: begin
                dec.fmt = is_sh ? F_SHAMT : F_I;
                dec.imm = is_sh ? imm_sh : imm_i;
            end
            7'b0100011:             begin dec.fmt = F_S; dec.imm = imm_s; end
            7'b1100011:             begin dec.fmt = F_B; dec.imm = imm_b; end
            7'b0110111, 7'b0010111: begin dec.fmt = F_U; dec.imm = imm_u; end
            7'b1101111:             begin dec.fmt = F_J; dec.imm = imm_j; end
            default:                dec.ill = 1'b1;
        endcase
    end

    assign acc = bus.in_valid_i && (state_q != TWO);
    assign pop = (state_q != EMPTY) && bus.out_ready_i;

    // out_q is the presented head; skid_q only holds data in TWO
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        if (bus.flush_i) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: if (acc) begin
                    out_d   = dec;
                    state_d = ONE;
                end
                ONE: begin
                    if (acc && pop) begin
                        out_d = dec;
                    end else if (acc) begin
                        skid_d  = dec;
                        state_d = TWO;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                TWO: if (pop) begin
                    out_d   = skid_q;
                    state_d = ONE;
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
        end
    end

    assign bus.in_ready_o  = (state_q != TWO);
    assign bus.out_valid_o = (state_q != EMPTY);
    assign bus.imm_o       = out_q.imm;
    assign bus.fmt_o       = out_q.fmt;
    assign bus.illegal_o   = out_q.ill;
    assign bus.tag_o       = out_q.tag;
endmodule
